hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Pipeline hazard controller that drives the control side of the decode/execute and fetch/decode latches. It owns the decode-side stall, bubble and squash decisions. It keeps a shadow scoreboard of the E, M and W stages to detect RAW hazards and to drain the pipeline on HALT. Its nop_de output is registered so that it lines up with the D/E latch output. That latch masks instruction_e to NOP (16'h0800) whenever nop_de is high.

Parameters:
FORWARDING, 1, 1 = E/M-to-E forwarding exists so only load-use stalls; 0 = no forwarding, stall on any E/M producer match.
CNT_WIDTH, 16, width of the saturating stall-cycle counter.

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-low
instruction_d  input  16  instruction in decode; rs=[10:8], rt=[7:5]
usesRs_d  input  1  decode instruction reads rs
usesRt_d  input  1  decode instruction reads rt
regWrite_d  input  1  decode instruction writes a register
writeRegSel_d  input  3  decode destination register
memRead_d  input  1  decode instruction is a load
halt_d  input  1  decode instruction is HALT
flush_e  input  1  taken branch/jump resolved in execute this cycle
stall_fd  output  1  hold PC and F/D latch (combinational)
flush_fd  output  1  squash F/D latch contents (combinational, = flush_e)
nop_de  output  1  registered; D/E latch output is a bubble this cycle
halted  output  1  sticky; pipeline drained after HALT
stallCount  output  CNT_WIDTH  cycles with stall_fd=1 caused by a RAW hazard, saturating

Behaviour:
- Scoreboard: three entries, E, M and W. Each entry holds {valid, regWrite, dest[2:0], memRead}. Every cycle W<=M and M<=E.
- E is loaded from the decode signals when decode is accepted. Otherwise it is loaded with a bubble (all zero).
- Decode is accepted when there is no hazard, flush_e=0 and state=RUN.
- Register r0 is an ordinary register; there is no zero-register exemption.
- The register file bypasses write-before-read, so the W entry never causes a stall.
- Match(x) = x.valid & x.regWrite & ((usesRs_d & x.dest==rs) | (usesRt_d & x.dest==rt)).
- hazard when FORWARDING=1: Match(E) & E.memRead.
- hazard when FORWARDING=0: Match(E) | Match(M).
- flush_e has priority over hazard:
  - flush_fd=1 and stall_fd=0.
  - The decode instruction is squashed and does not enter the scoreboard.
  - The next nop_de=1.
  - stallCount is not incremented.
- Stall cycle (hazard & !flush_e & RUN): stall_fd=1, next nop_de=1, E gets a bubble, stallCount+1 unless it is at all-ones.
- nop_de register: next = !accepted. The reset value is 1, because the latch resets its instruction to 0x0000 (HALT) and that must be masked.
- FSM states: RUN, DRAIN, HALTED.
  - RUN->DRAIN when halt_d is accepted. The HALT enters E with valid=1 and regWrite=0.
  - In DRAIN: stall_fd=1, next nop_de=1, and a 2-bit counter loaded with 0 runs to 2 (HALT moves E->M->W). On the cycle after it reaches 2, the FSM goes to HALTED.
  - In HALTED: stall_fd=1, nop_de=1, halted=1. Leaving HALTED requires reset.
  - flush_e is ignored in DRAIN and HALTED, because no instruction older than HALT is left in E.
  - DRAIN/HALTED stall cycles do not count in stallCount.
- A HALT that is hazard-stalled or flushed is not accepted, so the FSM stays in RUN.
- Reset assertion at any time takes effect immediately and asynchronously:
  - Scoreboard is cleared, state=RUN, drain counter=0, stallCount=0.
  - nop_de=1, halted=0.
  - stall_fd and flush_fd follow from the cleared state.

Test Plan:
- Load-use, FORWARDING=1: cycle 0 D=LD r1; cycle 1 D=ADD r2,r1,r3 -> stall_fd=1 only in cycle 1, nop_de=1 in cycle 2, ADD accepted in cycle 2, stallCount=1.
- ALU dependence, FORWARDING=0: cycle 0 D=ADDI r1; cycle 1 D reads r1 -> stall_fd=1 in cycles 1-2, nop_de=1 in cycles 2-3, accepted in cycle 3, stallCount=2. The same sequence with FORWARDING=1 gives zero stalls.
- Flush overrides hazard: load-use hazard and flush_e=1 in the same cycle -> stall_fd=0, flush_fd=1, next nop_de=1, stallCount unchanged, E holds a bubble.
- HALT drain: HALT accepted in cycle 0 -> stall_fd=1 from cycle 1 on, nop_de=1 from cycle 1 on, halted=1 from cycle 4, sticky for 20 more cycles.
- Reset: rst driven low mid-stall and mid-DRAIN -> nop_de=1, halted=0, stallCount=0, stall_fd=0 immediately, without a clock edge. After release, independent instructions are accepted every cycle.
- Saturation, CNT_WIDTH=4: 20 consecutive hazard cycles -> stallCount stays at 15.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: decode-side hazard controller for a 5-stage pipeline.
// Keeps a shadow scoreboard of in-flight producers and decides decode
// stall, bubble and squash. It also drains the pipeline on HALT.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   instruction_d       decode instruction (rs=[10:8], rt=[7:5])
//   usesRs_d/usesRt_d   decode reads rs / rt
//   regWrite_d          decode writes writeRegSel_d
//   memRead_d           decode is a load
//   halt_d              decode is HALT
//   flush_e             taken branch/jump resolved in execute
//   stall_fd            hold PC and F/D latch (combinational)
//   flush_fd            squash F/D latch contents (combinational)
//   nop_de              registered; D/E latch output is a bubble
//   halted              sticky; pipeline drained after HALT
//   stallCount          saturating count of RAW-hazard stall cycles
module hazard_stall_ctrl #(
  parameter bit          FORWARDING = 1'b1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          instruction_d,
  input  logic                 usesRs_d,
  input  logic                 usesRt_d,
  input  logic                 regWrite_d,
  input  logic [2:0]           writeRegSel_d,
  input  logic                 memRead_d,
  input  logic                 halt_d,
  input  logic                 flush_e,
  output logic                 stall_fd,
  output logic                 flush_fd,
  output logic                 nop_de,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] stallCount
);

  localparam int unsigned REG_W   = 3;
  localparam int unsigned DRAIN_W = 2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic [REG_W-1:0] dest;
    logic             mem_read;
  } sb_entry_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DRAIN_W-1:0]   r_drain_cnt;
  logic [DRAIN_W-1:0]   w_drain_cnt_nxt;
  sb_entry_t            r_sb_e;
  sb_entry_t            r_sb_m;
  sb_entry_t            w_sb_e_nxt;
  logic                 r_nop_de;
  logic                 r_halted;
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  logic [REG_W-1:0]     w_rs;
  logic [REG_W-1:0]     w_rt;
  logic                 w_match_e;
  logic                 w_match_m;
  logic                 w_hazard;
  logic                 w_accept;
  logic                 w_haz_stall;
  logic                 w_stall_fd;
  logic                 w_flush_fd;
  logic                 w_unused_bits;

  // The W stage needs no storage: the register file bypasses
  // write-before-read, so a W producer never stalls decode.
  assign w_rs = instruction_d[10:8];
  assign w_rt = instruction_d[7:5];

  // Fields and stages that a given FORWARDING setting does not consult.
  assign w_unused_bits = ^{instruction_d[15:11], instruction_d[4:0],
                           r_sb_m, r_sb_e.mem_read};

  // RAW source match against the E and M producers.
  assign w_match_e = r_sb_e.valid & r_sb_e.reg_write &
                     ((usesRs_d & (r_sb_e.dest == w_rs)) |
                      (usesRt_d & (r_sb_e.dest == w_rt)));
  assign w_match_m = r_sb_m.valid & r_sb_m.reg_write &
                     ((usesRs_d & (r_sb_m.dest == w_rs)) |
                      (usesRt_d & (r_sb_m.dest == w_rt)));

  // With forwarding only a load in E is too late to bypass.
  assign w_hazard = FORWARDING ? (w_match_e & r_sb_e.mem_read)
                               : (w_match_e | w_match_m);

  // Next-state and decode-control decisions.
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    w_accept        = 1'b0;
    w_haz_stall     = 1'b0;
    w_stall_fd      = 1'b0;
    w_flush_fd      = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        // A flush wins over a hazard: the decode slot is squashed, not held.
        w_flush_fd  = flush_e;
        w_haz_stall = w_hazard & ~flush_e;
        w_stall_fd  = w_haz_stall;
        w_accept    = ~w_hazard & ~flush_e;
        if (w_accept && halt_d) begin
          w_state_nxt     = ST_DRAIN;
          w_drain_cnt_nxt = '0;
        end
      end
      ST_DRAIN: begin
        // HALT walks E->M->W while decode is frozen.
        w_stall_fd = 1'b1;
        if (r_drain_cnt == DRAIN_W'(2)) begin
          w_state_nxt = ST_HALTED;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt + DRAIN_W'(1);
        end
      end
      ST_HALTED: begin
        w_stall_fd = 1'b1;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // E entry: accepted decode, or a bubble. HALT never writes a register.
  always_comb begin
    w_sb_e_nxt = '0;
    if (w_accept) begin
      w_sb_e_nxt.valid     = 1'b1;
      w_sb_e_nxt.reg_write = regWrite_d & ~halt_d;
      w_sb_e_nxt.dest      = writeRegSel_d;
      w_sb_e_nxt.mem_read  = memRead_d & ~halt_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  // Scoreboard shift, bubble flag, halted flag and stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sb_e      <= '0;
      r_sb_m      <= '0;
      r_nop_de    <= 1'b1;
      r_halted    <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_sb_e   <= w_sb_e_nxt;
      r_sb_m   <= r_sb_e;
      r_nop_de <= ~w_accept;
      r_halted <= (w_state_nxt == ST_HALTED);
      if (w_haz_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign stall_fd   = w_stall_fd;
  assign flush_fd   = w_flush_fd;
  assign nop_de     = r_nop_de;
  assign halted     = r_halted;
  assign stallCount = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: three instances (forwarding, no forwarding,
// no forwarding with a 4-bit counter) share stimulus and are checked
// against a history-based reference model each cycle.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instruction_d;
  logic        usesRs_d, usesRt_d, regWrite_d, memRead_d, halt_d, flush_e;
  logic [2:0]  writeRegSel_d;
  logic [2:0]  stall_fd, flush_fd, nop_de, halted;
  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.FORWARDING(1'b1), .CNT_WIDTH(16)) u_fwd (
    .clk(clk), .rst(rst), .instruction_d(instruction_d),
    .usesRs_d(usesRs_d), .usesRt_d(usesRt_d), .regWrite_d(regWrite_d),
    .writeRegSel_d(writeRegSel_d), .memRead_d(memRead_d), .halt_d(halt_d),
    .flush_e(flush_e), .stall_fd(stall_fd[0]), .flush_fd(flush_fd[0]),
    .nop_de(nop_de[0]), .halted(halted[0]), .stallCount(cnt_a));

  hazard_stall_ctrl #(.FORWARDING(1'b0), .CNT_WIDTH(16)) u_nofwd (
    .clk(clk), .rst(rst), .instruction_d(instruction_d),
    .usesRs_d(usesRs_d), .usesRt_d(usesRt_d), .regWrite_d(regWrite_d),
    .writeRegSel_d(writeRegSel_d), .memRead_d(memRead_d), .halt_d(halt_d),
    .flush_e(flush_e), .stall_fd(stall_fd[1]), .flush_fd(flush_fd[1]),
    .nop_de(nop_de[1]), .halted(halted[1]), .stallCount(cnt_b));

  hazard_stall_ctrl #(.FORWARDING(1'b0), .CNT_WIDTH(4)) u_sat (
    .clk(clk), .rst(rst), .instruction_d(instruction_d),
    .usesRs_d(usesRs_d), .usesRt_d(usesRt_d), .regWrite_d(regWrite_d),
    .writeRegSel_d(writeRegSel_d), .memRead_d(memRead_d), .halt_d(halt_d),
    .flush_e(flush_e), .stall_fd(stall_fd[2]), .flush_fd(flush_fd[2]),
    .nop_de(nop_de[2]), .halted(halted[2]), .stallCount(cnt_c));

  // Reference model: producers remembered by age (1 = one cycle old).
  typedef struct {
    bit       v;
    bit       w;
    bit [2:0] d;
    bit       ld;
  } prod_t;

  bit    fwd_of[3]  = '{1'b1, 1'b0, 1'b0};
  int    cmax_of[3] = '{65535, 65535, 15};
  prod_t hist[3][2];
  bit    m_nop[3];
  int    m_stalls[3];
  int    halt_cyc[3];
  int    cyc;
  int    n_cmp  = 0;
  int    n_fail = 0;

  // 0 = running, 1 = draining, 2 = halted; from age of the accepted HALT.
  function automatic int mode(int i);
    if (halt_cyc[i] < 0) return 0;
    if (cyc - halt_cyc[i] >= 4) return 2;
    return 1;
  endfunction

  function automatic bit hazard(int i);
    bit       h = 1'b0;
    bit [2:0] rs = instruction_d[10:8];
    bit [2:0] rt = instruction_d[7:5];
    int       oldest = fwd_of[i] ? 1 : 2;
    for (int a = 1; a <= oldest; a++) begin
      prod_t p = hist[i][a-1];
      if (p.v && p.w && ((usesRs_d && p.d == rs) || (usesRt_d && p.d == rt)) &&
          (!fwd_of[i] || p.ld))
        h = 1'b1;
    end
    return h;
  endfunction

  function automatic logic [31:0] cnt_of(int i);
    case (i)
      0:       return 32'(cnt_a);
      1:       return 32'(cnt_b);
      default: return 32'(cnt_c);
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      hist[i][0]  = '{0, 0, 3'd0, 0};
      hist[i][1]  = '{0, 0, 3'd0, 0};
      m_nop[i]    = 1'b1;
      m_stalls[i] = 0;
      halt_cyc[i] = -1;
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 3; i++) begin
      int md = mode(i);
      bit h  = hazard(i);
      int ec = (m_stalls[i] > cmax_of[i]) ? cmax_of[i] : m_stalls[i];
      check($sformatf("stall_fd[%0d]@%0d", i, cyc), 32'(stall_fd[i]),
            32'((md != 0) || (h && !flush_e)));
      check($sformatf("flush_fd[%0d]@%0d", i, cyc), 32'(flush_fd[i]),
            32'((md == 0) && flush_e));
      check($sformatf("nop_de[%0d]@%0d", i, cyc), 32'(nop_de[i]), 32'(m_nop[i]));
      check($sformatf("halted[%0d]@%0d", i, cyc), 32'(halted[i]), 32'(md == 2));
      check($sformatf("stallCount[%0d]@%0d", i, cyc), cnt_of(i), 32'(ec));
    end
  endtask

  task automatic model_clock();
    for (int i = 0; i < 3; i++) begin
      int md  = mode(i);
      bit h   = hazard(i);
      bit acc = (md == 0) && !h && !flush_e;
      if (md == 0 && h && !flush_e) m_stalls[i]++;
      m_nop[i]   = !acc;
      hist[i][1] = hist[i][0];
      if (acc) hist[i][0] = '{1'b1, regWrite_d && !halt_d, writeRegSel_d, memRead_d};
      else     hist[i][0] = '{0, 0, 3'd0, 0};
      if (acc && halt_d) halt_cyc[i] = cyc;
    end
    cyc++;
  endtask

  // One cycle: check away from the edge, then advance the model on the edge.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic drive(bit [2:0] rs, bit [2:0] rt, bit urs, bit urt, bit rw,
                       bit [2:0] wd, bit ld, bit h, bit fl);
    instruction_d = {5'h1f, rs, rt, 5'h15};
    usesRs_d      = urs;
    usesRt_d      = urt;
    regWrite_d    = rw;
    writeRegSel_d = wd;
    memRead_d     = ld;
    halt_d        = h;
    flush_e       = fl;
  endtask

  task automatic idle();
    drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rst_check(string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_nop[%0d]", tag, i), 32'(nop_de[i]), 32'd1);
      check($sformatf("%s_halted[%0d]", tag, i), 32'(halted[i]), 32'd0);
      check($sformatf("%s_stall[%0d]", tag, i), 32'(stall_fd[i]), 32'd0);
      check($sformatf("%s_cnt[%0d]", tag, i), cnt_of(i), 32'd0);
    end
  endtask

  // Called at a negedge with rst low; releases it and clocks one idle cycle.
  task automatic release_reset();
    rst = 1'b1;
    @(posedge clk);
    model_clock();
    #1;
  endtask

  initial begin
    cyc = 0;
    rst = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_check("por");
    release_reset();

    // Load-use: LD r1 then ADD r2,r1,r3.
    drive(3'd0, 3'd0, 0, 0, 1, 3'd1, 1, 0, 0); step();
    drive(3'd1, 3'd3, 1, 1, 1, 3'd2, 0, 0, 0); repeat (3) step();
    idle(); repeat (2) step();

    // ALU dependence: ADDI r1 then a reader of r1.
    drive(3'd0, 3'd0, 0, 0, 1, 3'd1, 0, 0, 0); step();
    drive(3'd5, 3'd1, 0, 1, 1, 3'd6, 0, 0, 0); repeat (3) step();
    idle(); repeat (2) step();

    // Flush in the same cycle as a load-use hazard, then the reader retries.
    drive(3'd0, 3'd0, 0, 0, 1, 3'd4, 1, 0, 0); step();
    drive(3'd4, 3'd0, 1, 0, 1, 3'd3, 0, 0, 1); step();
    drive(3'd4, 3'd0, 1, 0, 1, 3'd3, 0, 0, 0); repeat (2) step();
    idle(); repeat (2) step();

    // Random traffic without HALT; drives the 4-bit counter into saturation.
    for (int n = 0; n < 400; n++) begin
      bit rw = 1'($urandom);
      drive(3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), rw,
            3'($urandom), rw & 1'($urandom), 1'b0, ($urandom_range(7) == 0));
      step();
    end
    idle(); step();

    // Reset mid-stall: asynchronous, checked without a clock edge.
    drive(3'd0, 3'd0, 0, 0, 1, 3'd5, 1, 0, 0); step();
    drive(3'd5, 3'd5, 1, 1, 1, 3'd2, 0, 0, 0);
    #2 rst = 1'b0;
    #1 rst_check("rst_stall");
    model_reset();
    idle();
    @(negedge clk);
    release_reset();

    // Independent instructions flow every cycle after reset.
    for (int n = 0; n < 6; n++) begin
      drive(3'd7, 3'd7, 1, 1, 1, 3'(n), 1'(n & 1), 0, 0);
      step();
    end
    idle(); repeat (2) step();

    // HALT drain and sticky halted.
    drive(3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 1, 0); step();
    idle(); repeat (24) step();

    // Reset mid-DRAIN.
    rst = 1'b0;
    #1 rst_check("rst_halted");
    model_reset();
    @(negedge clk);
    release_reset();
    drive(3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 1, 0); step();
    idle(); step();
    #2 rst = 1'b0;
    #1 rst_check("rst_drain");
    model_reset();
    @(negedge clk);
    release_reset();
    for (int n = 0; n < 4; n++) begin
      drive(3'd6, 3'd6, 0, 1, 1, 3'(n + 1), 0, 0, 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
